// File: rtl/ds18b20_sched.sv
// DS18B20 sample scheduler: paces driver resets, validates and converts readings,
// applies a hysteretic high-temperature alarm and tracks acquisition faults.
module ds18b20_sched #(
    parameter int unsigned CLK_HZ      = 12000000,
    parameter int unsigned SAMPLE_MS   = 1000,
    parameter int unsigned TIMEOUT_MS  = 1500,
    parameter int unsigned HYST_X10    = 20,
    parameter int unsigned FAULT_LIMIT = 3
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        enable,
    input  logic        sample_now,
    input  logic [11:0] hi_thresh,
    input  logic [15:0] sensor_data,
    input  logic        sensor_data_en,
    output logic        sensor_rst_n,
    output logic [15:0] temp_raw,
    output logic [11:0] temp_x10,
    output logic        temp_valid,
    output logic        sample_err,
    output logic        alarm_hi,
    output logic        fault,
    output logic        busy,
    output logic [7:0]  err_cnt
);
    localparam int unsigned TICK_CYC = CLK_HZ / 1000;
    localparam int unsigned PW       = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
    localparam int unsigned SW       = $clog2(SAMPLE_MS + 1);
    localparam int unsigned TW       = $clog2(TIMEOUT_MS + 1);
    localparam int unsigned GAP      = 16;
    localparam int unsigned GW       = 5;
    localparam int unsigned CW       = 8;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACQ  = 2'd2,
        ST_CAPT = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [SW-1:0]   period_q, period_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [GW-1:0]   rst_low_q, rst_low_d;
    logic [CW-1:0]   consec_q, consec_d;
    logic [7:0]      err_cnt_q, err_cnt_d;
    logic [15:0]     temp_raw_q, temp_raw_d;
    logic [11:0]     temp_x10_q, temp_x10_d;
    logic            pending_q, pending_d;
    logic            data_en_q, data_en_d;
    logic            sensor_rst_n_q, sensor_rst_n_d;
    logic            busy_q, busy_d;
    logic            temp_valid_q, temp_valid_d;
    logic            sample_err_q, sample_err_d;
    logic            alarm_q, alarm_d;
    logic            fault_q, fault_d;

    logic            tick;
    logic            period_wrap;
    logic            take_ok;
    logic            take_err;
    logic            raw_ok;
    logic            alarm_new;
    logic [11:0]     x10_new;
    logic [CW-1:0]   consec_inc;
    logic signed [19:0] raw_sx;
    logic signed [13:0] x10_s, thr_s, thr_lo_s;

    // 1 ms prescaler and start-to-start period counter, both frozen at zero while disabled
    always_comb begin
        tick        = 1'b0;
        period_wrap = 1'b0;
        presc_d     = '0;
        period_d    = '0;
        if (enable) begin
            tick     = (presc_q == PW'(TICK_CYC - 1));
            presc_d  = tick ? '0 : presc_q + PW'(1);
            period_d = period_q;
            if (tick) begin
                if (period_q == SW'(SAMPLE_MS - 1)) begin
                    period_d    = '0;
                    period_wrap = 1'b1;
                end else begin
                    period_d = period_q + SW'(1);
                end
            end
        end
    end

    // Raw code check, floor-scaled conversion to 0.1 C and alarm hysteresis decision
    always_comb begin
        raw_sx    = {{4{sensor_data[15]}}, sensor_data};
        x10_new   = 12'((raw_sx * 20'sd10) >>> 4);
        raw_ok    = (sensor_data != 16'hFFFF) &&
                    ((sensor_data[15:11] == 5'h00) || (sensor_data[15:11] == 5'h1F));
        x10_s     = {{2{x10_new[11]}}, x10_new};
        thr_s     = {{2{hi_thresh[11]}}, hi_thresh};
        thr_lo_s  = thr_s - 14'(HYST_X10);
        alarm_new = alarm_q;
        if (x10_s >= thr_s) begin
            alarm_new = 1'b1;
        end else if (x10_s < thr_lo_s) begin
            alarm_new = 1'b0;
        end
    end

    // Scheduler FSM with sample acceptance and error bookkeeping
    always_comb begin
        state_d      = state_q;
        pending_d    = pending_q;
        tmo_d        = tmo_q;
        data_en_d    = sensor_data_en;
        temp_raw_d   = temp_raw_q;
        temp_x10_d   = temp_x10_q;
        alarm_d      = alarm_q;
        fault_d      = fault_q;
        consec_d     = consec_q;
        err_cnt_d    = err_cnt_q;
        temp_valid_d = 1'b0;
        sample_err_d = 1'b0;
        take_ok      = 1'b0;
        take_err     = 1'b0;
        consec_inc   = (consec_q == '1) ? consec_q : consec_q + CW'(1);
        rst_low_d    = sensor_rst_n_q ? '0 :
                       ((rst_low_q >= GW'(GAP)) ? rst_low_q : rst_low_q + GW'(1));

        if (period_wrap || sample_now) begin
            pending_d = 1'b1;
        end

        if (!enable) begin
            state_d   = ST_OFF;
            pending_d = 1'b0;
            tmo_d     = '0;
        end else begin
            case (state_q)
                ST_OFF: begin
                    state_d   = ST_WAIT;
                    pending_d = 1'b1;
                end
                ST_WAIT: begin
                    if (pending_q && (rst_low_q >= GW'(GAP))) begin
                        state_d   = ST_ACQ;
                        pending_d = period_wrap || sample_now;
                        tmo_d     = '0;
                    end
                end
                ST_ACQ: begin
                    if (tick) begin
                        tmo_d = tmo_q + TW'(1);
                    end
                    // a data edge takes precedence over a timeout in the same cycle
                    if (sensor_data_en && !data_en_q) begin
                        state_d  = ST_CAPT;
                        take_ok  = raw_ok;
                        take_err = !raw_ok;
                    end else if (tick && (tmo_q == TW'(TIMEOUT_MS - 1))) begin
                        state_d  = ST_WAIT;
                        take_err = 1'b1;
                    end
                end
                ST_CAPT: begin
                    state_d = ST_WAIT;
                end
                default: begin
                    state_d = ST_OFF;
                end
            endcase
        end

        if (take_ok) begin
            temp_raw_d   = sensor_data;
            temp_x10_d   = x10_new;
            alarm_d      = alarm_new;
            temp_valid_d = 1'b1;
            consec_d     = '0;
            fault_d      = 1'b0;
        end
        if (take_err) begin
            sample_err_d = 1'b1;
            err_cnt_d    = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
            consec_d     = consec_inc;
            if (consec_inc >= CW'(FAULT_LIMIT)) begin
                fault_d = 1'b1;
            end
        end

        sensor_rst_n_d = (state_d == ST_ACQ);
        busy_d         = (state_d == ST_ACQ);
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q        <= ST_OFF;
            presc_q        <= '0;
            period_q       <= '0;
            tmo_q          <= '0;
            rst_low_q      <= '0;
            consec_q       <= '0;
            err_cnt_q      <= '0;
            temp_raw_q     <= '0;
            temp_x10_q     <= '0;
            pending_q      <= 1'b0;
            data_en_q      <= 1'b0;
            sensor_rst_n_q <= 1'b0;
            busy_q         <= 1'b0;
            temp_valid_q   <= 1'b0;
            sample_err_q   <= 1'b0;
            alarm_q        <= 1'b0;
            fault_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            presc_q        <= presc_d;
            period_q       <= period_d;
            tmo_q          <= tmo_d;
            rst_low_q      <= rst_low_d;
            consec_q       <= consec_d;
            err_cnt_q      <= err_cnt_d;
            temp_raw_q     <= temp_raw_d;
            temp_x10_q     <= temp_x10_d;
            pending_q      <= pending_d;
            data_en_q      <= data_en_d;
            sensor_rst_n_q <= sensor_rst_n_d;
            busy_q         <= busy_d;
            temp_valid_q   <= temp_valid_d;
            sample_err_q   <= sample_err_d;
            alarm_q        <= alarm_d;
            fault_q        <= fault_d;
        end
    end

    assign sensor_rst_n = sensor_rst_n_q;
    assign busy         = busy_q;
    assign temp_raw     = temp_raw_q;
    assign temp_x10     = temp_x10_q;
    assign temp_valid   = temp_valid_q;
    assign sample_err   = sample_err_q;
    assign alarm_hi     = alarm_q;
    assign fault        = fault_q;
    assign err_cnt      = err_cnt_q;

endmodule

// File: tb/tb_ds18b20_sched.sv
// Bench for ds18b20_sched: plays the sensor driver and scores every sample
// against a transaction-level model of conversion, alarm and fault rules.
module tb_ds18b20_sched;
    localparam int unsigned CLK_HZ      = 20000;
    localparam int unsigned SAMPLE_MS   = 20;
    localparam int unsigned TIMEOUT_MS  = 5;
    localparam int unsigned HYST_X10    = 20;
    localparam int unsigned FAULT_LIMIT = 3;
    localparam int          TICK        = CLK_HZ / 1000;

    logic        clk_in = 1'b0;
    logic        rst_n_in = 1'b0;
    logic        enable = 1'b0;
    logic        sample_now = 1'b0;
    logic [11:0] hi_thresh = 12'd300;
    logic [15:0] sensor_data = 16'h0000;
    logic        sensor_data_en = 1'b0;
    logic        sensor_rst_n;
    logic [15:0] temp_raw;
    logic [11:0] temp_x10;
    logic        temp_valid;
    logic        sample_err;
    logic        alarm_hi;
    logic        fault;
    logic        busy;
    logic [7:0]  err_cnt;

    ds18b20_sched #(
        .CLK_HZ     (CLK_HZ),
        .SAMPLE_MS  (SAMPLE_MS),
        .TIMEOUT_MS (TIMEOUT_MS),
        .HYST_X10   (HYST_X10),
        .FAULT_LIMIT(FAULT_LIMIT)
    ) dut (
        .clk_in        (clk_in),
        .rst_n_in      (rst_n_in),
        .enable        (enable),
        .sample_now    (sample_now),
        .hi_thresh     (hi_thresh),
        .sensor_data   (sensor_data),
        .sensor_data_en(sensor_data_en),
        .sensor_rst_n  (sensor_rst_n),
        .temp_raw      (temp_raw),
        .temp_x10      (temp_x10),
        .temp_valid    (temp_valid),
        .sample_err    (sample_err),
        .alarm_hi      (alarm_hi),
        .fault         (fault),
        .busy          (busy),
        .err_cnt       (err_cnt)
    );

    always #5 clk_in = ~clk_in;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int last_done = 0;
    int seen_tv = 0;
    int seen_se = 0;

    // reference model state
    logic [15:0] m_raw = 16'h0000;
    int          m_x10 = 0;
    int          m_alarm = 0;
    int          m_fault = 0;
    int          m_consec = 0;
    int          m_err = 0;
    int          m_tv = 0;
    int          m_se = 0;

    always @(posedge clk_in) cyc <= cyc + 1;

    always @(negedge clk_in) begin
        if (rst_n_in) begin
            if (temp_valid) seen_tv++;
            if (sample_err) seen_se++;
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: time limit reached, passed %0d of %0d", n_pass, n_chk);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic int sx12(input logic [11:0] v);
        return int'($signed(v));
    endfunction

    function automatic int to_x10(input logic [15:0] raw);
        int p;
        p = int'($signed(raw)) * 10;
        return (p >= 0) ? p / 16 : -((-p + 15) / 16);
    endfunction

    function automatic bit raw_valid(input logic [15:0] raw);
        return (raw != 16'hFFFF) && (raw[15:11] == 5'h00 || raw[15:11] == 5'h1F);
    endfunction

    task automatic model_accept(input logic [15:0] raw);
        int thr;
        thr     = sx12(hi_thresh);
        m_raw   = raw;
        m_x10   = to_x10(raw);
        if (m_x10 >= thr) m_alarm = 1;
        else if (m_x10 < thr - int'(HYST_X10)) m_alarm = 0;
        m_consec = 0;
        m_fault  = 0;
        m_tv++;
    endtask

    task automatic model_error();
        m_se++;
        if (m_err < 255) m_err++;
        m_consec++;
        if (m_consec >= int'(FAULT_LIMIT)) m_fault = 1;
    endtask

    task automatic check_state();
        check("temp_raw", int'(temp_raw), int'(m_raw));
        check("temp_x10", sx12(temp_x10), m_x10);
        check("alarm_hi", int'(alarm_hi), m_alarm);
        check("fault", int'(fault), m_fault);
        check("err_cnt", int'(err_cnt), m_err);
    endtask

    task automatic wait_release(input int limit, output int waited);
        waited = 0;
        while (sensor_rst_n !== 1'b1 && waited < limit) begin
            @(negedge clk_in);
            waited++;
        end
    endtask

    // one acquisition: respond with raw after dly cycles, or stay silent until timeout
    task automatic run_sample(input bit respond, input logic [15:0] raw, input int dly, input bit poke);
        int w;
        int n;
        bit got;
        wait_release(1000, w);
        check("release", int'(sensor_rst_n), 1);
        check("busy_acq", int'(busy), 1);
        check("gap_min16", int'((cyc - last_done) >= 16), 1);
        if (poke) begin
            sample_now = 1'b1;
            @(negedge clk_in);
            sample_now = 1'b0;
        end
        if (respond) begin
            repeat (dly) @(negedge clk_in);
            sensor_data    = raw;
            sensor_data_en = 1'b1;
            @(negedge clk_in);
            if (raw_valid(raw)) begin
                model_accept(raw);
                check("temp_valid", int'(temp_valid), 1);
                check("no_err", int'(sample_err), 0);
            end else begin
                model_error();
                check("sample_err", int'(sample_err), 1);
                check("no_valid", int'(temp_valid), 0);
            end
            check("rst_low_on_pulse", int'(sensor_rst_n), 0);
            check("busy_capt", int'(busy), 0);
            check_state();
            last_done = cyc;
            repeat (11) @(negedge clk_in);
            sensor_data_en = 1'b0;
            sensor_data    = 16'($urandom);
        end else begin
            n   = 0;
            got = 1'b0;
            while (!got && n < 200) begin
                @(negedge clk_in);
                n++;
                got = sample_err;
            end
            model_error();
            check("tmo_seen", int'(got), 1);
            check("tmo_window", int'(n >= (int'(TIMEOUT_MS) - 1) * TICK + 1 && n <= int'(TIMEOUT_MS) * TICK), 1);
            check("rst_low_on_err", int'(sensor_rst_n), 0);
            check_state();
            last_done = cyc;
        end
    endtask

    initial begin
        int w;
        logic [15:0] alarm_raw [4];
        int          alarm_exp [4];
        alarm_raw = '{16'd480, 16'd464, 16'd447, 16'd448};
        alarm_exp = '{1, 1, 0, 0};

        repeat (3) @(negedge clk_in);
        check("rst_sensor_rst_n", int'(sensor_rst_n), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_temp_valid", int'(temp_valid), 0);
        check("rst_sample_err", int'(sample_err), 0);
        check("rst_temp_raw", int'(temp_raw), 0);
        check("rst_temp_x10", sx12(temp_x10), 0);
        check("rst_alarm", int'(alarm_hi), 0);
        check("rst_fault", int'(fault), 0);
        check("rst_err_cnt", int'(err_cnt), 0);
        rst_n_in = 1'b1;
        repeat (20) @(negedge clk_in);
        check("off_holds_reset", int'(sensor_rst_n), 0);

        enable = 1'b1;
        run_sample(1'b1, 16'h0191, 3, 1'b0);
        check("x10_0191", sx12(temp_x10), 250);
        check("raw_0191", int'(temp_raw), 16'h0191);
        run_sample(1'b1, 16'hFF5E, 7, 1'b0);
        check("x10_ff5e", sx12(temp_x10), -102);
        run_sample(1'b1, 16'h07D0, 0, 1'b0);
        check("x10_07d0", sx12(temp_x10), 1250);
        run_sample(1'b1, 16'hFC90, 20, 1'b0);
        check("x10_fc90", sx12(temp_x10), -550);

        hi_thresh = 12'd300;
        for (int i = 0; i < 4; i++) begin
            run_sample(1'b1, alarm_raw[i], 4, 1'b0);
            check("alarm_seq", int'(alarm_hi), alarm_exp[i]);
        end

        for (int i = 1; i <= 3; i++) begin
            run_sample(1'b0, 16'h0000, 0, 1'b0);
            check("tmo_err_cnt", int'(err_cnt), i);
            check("tmo_fault", int'(fault), (i >= 3) ? 1 : 0);
        end
        run_sample(1'b1, 16'h0191, 2, 1'b0);
        check("fault_cleared", int'(fault), 0);
        check("err_cnt_kept", int'(err_cnt), 3);

        run_sample(1'b1, 16'hFFFF, 5, 1'b0);
        run_sample(1'b1, 16'h0A00, 5, 1'b0);
        check("x10_held", sx12(temp_x10), 250);
        check("err_cnt_5", int'(err_cnt), 5);

        // drop enable mid-acquisition, with a data edge arriving in the same cycle
        wait_release(1000, w);
        repeat (3) @(negedge clk_in);
        enable         = 1'b0;
        sensor_data    = 16'h0100;
        sensor_data_en = 1'b1;
        @(negedge clk_in);
        check("drop_rst_low", int'(sensor_rst_n), 0);
        check("drop_busy", int'(busy), 0);
        check("drop_no_valid", int'(temp_valid), 0);
        check("drop_no_err", int'(sample_err), 0);
        last_done = cyc;
        repeat (30) @(negedge clk_in);
        check("off_idle", int'(sensor_rst_n), 0);
        check_state();
        sensor_data_en = 1'b0;
        @(negedge clk_in);

        enable = 1'b1;
        wait_release(10, w);
        check("enable_immediate", int'(w <= 3), 1);
        run_sample(1'b1, 16'h0140, 6, 1'b1);
        wait_release(40, w);
        check("follow_gap", int'((cyc - last_done) >= 16 && (cyc - last_done) <= 20), 1);
        run_sample(1'b1, 16'h01F4, 5, 1'b0);

        for (int i = 0; i < 24; i++) begin
            int kind;
            logic [15:0] raw;
            kind      = int'($urandom_range(0, 9));
            hi_thresh = 12'($urandom_range(200, 400));
            if (kind < 5) raw = 16'($urandom_range(400, 560));
            else if (kind < 7) raw = 16'(int'($urandom_range(0, 4095)) - 2048);
            else if (kind == 7) raw = 16'hFFFF;
            else raw = {5'b01101 ^ 5'($urandom_range(0, 3)), 11'($urandom)};
            run_sample(kind != 9, raw, int'($urandom_range(0, 60)), 1'b0);
        end

        repeat (5) @(negedge clk_in);
        check("count_valid", seen_tv, m_tv);
        check("count_err", seen_se, m_se);

        // asynchronous reset in the middle of an acquisition
        wait_release(1000, w);
        repeat (2) @(negedge clk_in);
        #2 rst_n_in = 1'b0;
        #1;
        check("arst_sensor_rst_n", int'(sensor_rst_n), 0);
        check("arst_busy", int'(busy), 0);
        check("arst_temp_x10", sx12(temp_x10), 0);
        check("arst_temp_raw", int'(temp_raw), 0);
        check("arst_err_cnt", int'(err_cnt), 0);
        check("arst_fault", int'(fault), 0);
        check("arst_alarm", int'(alarm_hi), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
